// File: rtl/mini_alu_pkg.sv
// Shared types and constants for the mini-ALU sequential core.
//   op_t        : opcode encoding driven on the op input
//   state_t     : control FSM states (also visible on the dbg_state output)
//   DISPLAY_MAX : largest value the six-digit decimal display can show
//   needs_calc  : true when an operation goes through the iterative datapath
package mini_alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      EXEC = 2'b10
   } state_t;

   localparam int unsigned DISPLAY_MAX = 999_999;

   // Multiply always iterates; divide iterates unless the divisor is zero,
   // in which case the answer is known immediately.
   function automatic logic needs_calc(input op_t op_code, input logic b_is_zero);
      return (op_code == OP_MUL) || ((op_code == OP_DIV) && !b_is_zero);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: shift-add multiplier and restoring divider.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : loads operands, latches mode and sets the counter to WIDTH
//   div_mode  : 0 = multiply a*b, 1 = divide a/b (sampled with load)
//   a, b      : unsigned operands (sampled with load)
//   count     : remaining iterations; one iteration per cycle while nonzero
//   value     : product (multiply) or zero-extended quotient (divide)
module alu_iter_unit #(
   parameter int WIDTH = 10,
   localparam int CW = $clog2(WIDTH + 1),
   localparam int RW = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [CW-1:0]    count,
   output logic [RW-1:0]    value
);

   // acc  : product accumulator (mul) / partial remainder (div)
   // opnd : left-shifting multiplicand (mul) / divisor in low bits (div)
   // sreg : right-shifting multiplier (mul) / dividend shifting out while
   //        quotient bits shift in from the bottom (div)
   logic [RW-1:0]    acc;
   logic [RW-1:0]    opnd;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             mode_q;

   logic [WIDTH:0]   div_shifted;
   logic [WIDTH:0]   div_divisor;
   logic [WIDTH:0]   div_diff;
   logic             q_bit;
   logic [RW-1:0]    div_acc_next;
   logic [RW-1:0]    mul_addend;

   // Restoring step: bring the next dividend bit into the remainder and
   // subtract the divisor only if it fits.
   always_comb begin
      div_shifted  = {acc[WIDTH-1:0], sreg[WIDTH-1]};
      div_divisor  = {1'b0, opnd[WIDTH-1:0]};
      div_diff     = div_shifted - div_divisor;
      q_bit        = (div_shifted >= div_divisor);
      div_acc_next = q_bit ? {{(WIDTH-1){1'b0}}, div_diff}
                           : {{(WIDTH-1){1'b0}}, div_shifted};
      mul_addend   = sreg[0] ? opnd : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         opnd   <= '0;
         sreg   <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
      end else if (load) begin
         mode_q <= div_mode;
         cnt    <= CW'(WIDTH);
         acc    <= '0;
         if (div_mode) begin
            opnd <= {{WIDTH{1'b0}}, b};
            sreg <= a;
         end else begin
            opnd <= {{WIDTH{1'b0}}, a};
            sreg <= b;
         end
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         if (mode_q) begin
            acc  <= div_acc_next;
            sreg <= {sreg[WIDTH-2:0], q_bit};
         end else begin
            acc  <= acc + mul_addend;
            opnd <= opnd << 1;
            sreg <= sreg >> 1;
         end
      end
   end

   assign count = cnt;
   assign value = mode_q ? {{WIDTH{1'b0}}, sreg} : acc;

endmodule

// File: rtl/mini_alu_seq.sv
// Sequential arithmetic core: add, subtract, multiply, divide on a start pulse.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   a, b, op   : operands and opcode, captured on an accepted start
//   start      : request pulse; accepted only when idle, otherwise dropped
//   busy       : operation in progress (accept edge up to write-back edge)
//   done       : one-cycle pulse following the write-back edge
//   result     : last completed result (feeds the decimal display unchanged)
//   negative   : last subtract had b > a
//   overflow   : last result exceeds DISPLAY_MAX
//   div_err    : last divide had b == 0
//   dbg_state  : current FSM state, for observation only
//
// Handshake: start is a single-cycle pulse with no back-pressure; it is
// honoured only while the FSM is in IDLE (busy low, which includes the done
// cycle). result and flags change only on the edge that raises done.
module mini_alu_seq
   import mini_alu_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         op,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               negative,
   output logic               overflow,
   output logic               div_err,
   output state_t             dbg_state
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           next_state;
   op_t              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             accept;
   logic             load_iter;
   logic [CW-1:0]    iter_count;
   logic [RW-1:0]    iter_value;

   logic [RW-1:0]    wb_result;
   logic             wb_neg;
   logic             wb_ovf;
   logic             wb_derr;

   alu_iter_unit #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .load     (load_iter),
      .div_mode (op == OP_DIV),
      .a        (a),
      .b        (b),
      .count    (iter_count),
      .value    (iter_value)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // The CALC exit fires on the edge of the final iteration (count == 1),
   // so the iterative result is ready when EXEC writes it back one edge later.
   always_comb begin
      next_state = state;
      load_iter  = 1'b0;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (needs_calc(op_t'(op), (b == '0))) begin
                  next_state = CALC;
                  load_iter  = 1'b1;
               end else begin
                  next_state = EXEC;
               end
            end
         end
         CALC: begin
            if (iter_count == CW'(1)) next_state = EXEC;
         end
         EXEC: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Write-back values; flags that do not apply to the opcode stay 0.
   always_comb begin
      wb_result = '0;
      wb_neg    = 1'b0;
      wb_derr   = 1'b0;
      unique case (op_q)
         OP_ADD: wb_result = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
         OP_SUB: begin
            if (b_q > a_q) begin
               wb_neg    = 1'b1;
               wb_result = {{WIDTH{1'b0}}, b_q - a_q};
            end else begin
               wb_result = {{WIDTH{1'b0}}, a_q - b_q};
            end
         end
         OP_MUL: wb_result = iter_value;
         OP_DIV: begin
            if (b_q == '0) wb_derr = 1'b1;
            else           wb_result = iter_value;
         end
         default: wb_result = '0;
      endcase
      wb_ovf = (64'(wb_result) > 64'(DISPLAY_MAX));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         done     <= 1'b0;
         result   <= '0;
         negative <= 1'b0;
         overflow <= 1'b0;
         div_err  <= 1'b0;
      end else begin
         done <= (state == EXEC);
         if (accept) begin
            op_q <= op_t'(op);
            a_q  <= a;
            b_q  <= b;
         end
         if (state == EXEC) begin
            result   <= wb_result;
            negative <= wb_neg;
            overflow <= wb_ovf;
            div_err  <= wb_derr;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_mini_alu_seq.sv
module tb_mini_alu_seq;
   import mini_alu_pkg::*;

   localparam int WIDTH = 10;
   localparam int RW    = 2 * WIDTH;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             start;
   logic             busy;
   logic             done;
   logic [RW-1:0]    result;
   logic             negative;
   logic             overflow;
   logic             div_err;
   state_t           dbg_state;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int k_cyc      = 0;

   // Scoreboard entries are {negative, overflow, div_err, result}.
   logic [RW+2:0] exp_q[$];
   int            lat_q[$];

   mini_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .op        (op),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .negative  (negative),
      .overflow  (overflow),
      .div_err   (div_err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [RW+2:0] model(input int unsigned av, input int unsigned bv,
                                           input logic [1:0] o);
      longint unsigned r;
      logic            n;
      logic            d;
      r = 0;
      n = 1'b0;
      d = 1'b0;
      case (o)
         2'd0: r = longint'(av) + longint'(bv);
         2'd1: begin
            n = (bv > av);
            r = n ? longint'(bv - av) : longint'(av - bv);
         end
         2'd2: r = longint'(av) * longint'(bv);
         default: begin
            if (bv == 0) d = 1'b1;
            else         r = longint'(av / bv);
         end
      endcase
      return {n, (r > 64'd999999), d, r[RW-1:0]};
   endfunction

   function automatic int exp_lat(input int unsigned bv, input logic [1:0] o);
      return ((o == 2'd2) || (o == 2'd3 && bv != 0)) ? (WIDTH + 1) : 1;
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a negedge; the following posedge is the accepting edge k.
   task automatic send(input int unsigned av, input int unsigned bv, input logic [1:0] o);
      a     = av[WIDTH-1:0];
      b     = bv[WIDTH-1:0];
      op    = o;
      start = 1'b1;
      exp_q.push_back(model(av, bv, o));
      lat_q.push_back(exp_lat(bv, o));
      @(negedge clk);
      start = 1'b0;
      a     = WIDTH'($urandom_range(0, 1023));
      b     = WIDTH'($urandom_range(0, 1023));
      op    = 2'($urandom_range(0, 3));
      k_cyc = cyc;
   endtask

   // Waits (bounded) for done; lat is -1 if it never arrives.
   task automatic wait_done(output int lat, output logic [RW+2:0] obs);
      lat = -1;
      obs = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - k_cyc;
            obs = {negative, overflow, div_err, result};
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      compared++;
      if ({busy, done, result, negative, overflow, div_err} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%0d n=%b o=%b e=%b expected all 0",
                  busy, done, result, negative, overflow, div_err);
      end
      compared++;
      if (dbg_state !== IDLE) begin
         mismatched++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Add / subtract / divide cases from a table, each checked on value and latency.
   task automatic test_arith();
      int unsigned ta[6] = '{1023, 5,  12, 1000, 5, 0};
      int unsigned tb[6] = '{1023, 12, 5,  7,    0, 0};
      logic [1:0]  to[6] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
      int lat;
      int el;
      logic [RW+2:0] obs;
      logic [RW+2:0] e;
      for (int i = 0; i < 6; i++) begin
         send(ta[i], tb[i], to[i]);
         wait_done(lat, obs);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         compared++;
         if (obs !== e) begin
            mismatched++;
            $display("FAIL arith_value[%0d]: got %h expected %h", i, obs, e);
         end
         compared++;
         if (lat != el) begin
            mismatched++;
            $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, el);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mul();
      int n;
      int el;
      logic [RW+2:0] e;
      send(1023, 1023, 2'd2);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      compared++;
      if (n != el) begin
         mismatched++;
         $display("FAIL mul_busy_cycles: got %0d expected %0d", n, el);
      end
      compared++;
      if (done !== 1'b1 || (cyc - k_cyc) != el) begin
         mismatched++;
         $display("FAIL mul_done_edge: got done=%b at +%0d expected 1 at +%0d", done, cyc - k_cyc, el);
      end
      compared++;
      if ({negative, overflow, div_err, result} !== e) begin
         mismatched++;
         $display("FAIL mul_max_value: got %h expected %h",
                  {negative, overflow, div_err, result}, e);
      end
      @(negedge clk);
      send(0, 517, 2'd2);
      wait_done(n, e);
      compared++;
      if (e !== exp_q.pop_front()) begin
         mismatched++;
         $display("FAIL mul_zero_value: got %h expected 0", e);
      end
      el = lat_q.pop_front();
      compared++;
      if (n != el) begin
         mismatched++;
         $display("FAIL mul_zero_latency: got %0d expected %0d", n, el);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int unsigned av;
      int unsigned bv;
      logic [1:0]  o;
      int lat;
      int el;
      logic [RW+2:0] obs;
      logic [RW+2:0] e;
      for (int i = 0; i < 12; i++) begin
         av = $urandom_range(0, 1023);
         bv = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 1023);
         o  = 2'($urandom_range(0, 3));
         send(av, bv, o);
         wait_done(lat, obs);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         compared++;
         if (obs !== e || lat != el) begin
            mismatched++;
            $display("FAIL random[%0d] a=%0d b=%0d op=%0d: got %h lat %0d expected %h lat %0d",
                     i, av, bv, o, obs, lat, e, el);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      int el;
      int pulses;
      logic [RW+2:0] obs;
      logic [RW+2:0] e;
      send(3, 4, 2'd2);
      repeat (3) @(negedge clk);
      a = 10'd7; b = 10'd9; op = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, obs);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      compared++;
      if (obs !== e || lat != el) begin
         mismatched++;
         $display("FAIL busy_ignore: got %h lat %0d expected %h lat %0d", obs, lat, e, el);
      end
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      compared++;
      if (pulses != 0) begin
         mismatched++;
         $display("FAIL busy_ignore_extra_done: got %0d pulses expected 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned ta[3] = '{25, 1000, 10};
      int unsigned tb[3] = '{40, 7,    20};
      logic [1:0]  to[3] = '{2'd2, 2'd3, 2'd0};
      int lat;
      int el;
      logic [RW+2:0] obs;
      logic [RW+2:0] e;
      @(negedge clk);
      // Each new start is driven in the cycle where the previous done is high.
      for (int i = 0; i < 3; i++) begin
         send(ta[i], tb[i], to[i]);
         wait_done(lat, obs);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         compared++;
         if (obs !== e || lat != el) begin
            mismatched++;
            $display("FAIL back_to_back[%0d]: got %h lat %0d expected %h lat %0d", i, obs, lat, e, el);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int pulses;
      send(1000, 7, 2'd3);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if ({busy, done, result, negative, overflow, div_err} !== '0) begin
         mismatched++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b result=%0d n=%b o=%b e=%b expected all 0",
                  busy, done, result, negative, overflow, div_err);
      end
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      compared++;
      if (pulses != 0 || result !== '0) begin
         mismatched++;
         $display("FAIL reset_mid_no_done: got %0d pulses result %0d expected 0 pulses result 0",
                  pulses, result);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      op    = 2'd0;
      test_reset();
      test_arith();
      test_mul();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mini_alu_seq.md
# mini_alu_seq

Sequential arithmetic core for the mini-ALU. It captures two unsigned operands and an opcode on a start pulse, then computes add, subtract, multiply or divide; multiply and divide use iterative shift-add and restoring-division datapaths. It holds a 20-bit unsigned result plus status flags. The block sits directly upstream of the six-digit decimal seven-segment display: `result` drives the display's 20-bit value input unchanged.

## Interface
- `WIDTH`, default 10: operand width; result width is 2*WIDTH (20 at default).
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `a  in  WIDTH`: operand A, unsigned; sampled only on an accepted start.
- `b  in  WIDTH`: operand B, unsigned; sampled only on an accepted start.
- `op  in  2`: opcode, sampled with operands. 00 is add, 01 is subtract, 10 is multiply, 11 is divide.
- `start  in  1`: single-cycle request pulse from the upstream debouncer.
- `busy  out  1`: operation in progress.
- `done  out  1`: one-cycle pulse; `result` and flags are updated on the same edge.
- `result  out  2*WIDTH`: last completed result, held until the next `done`.
- `negative  out  1`: the last subtract had b > a.
- `overflow  out  1`: the last result exceeds `DISPLAY_MAX` (999_999).
- `div_err  out  1`: the last divide had b == 0.

## Operation
- FSM states:
  - IDLE: a start is accepted only here.
  - CALC: iterative multiply or divide.
  - EXEC: result write-back.
- IDLE, start=1:
  - latch a, b and op; busy is set.
  - add, subtract, or divide with b == 0: next state is EXEC.
  - multiply, or divide with b != 0: next state is CALC, with the iteration counter set to WIDTH.
- CALC:
  - one iteration per cycle; counter decrements.
  - multiply: shift-add, one multiplier bit per cycle.
  - divide: restoring, one quotient bit per cycle.
  - when the counter reaches 0, next state is EXEC.
- EXEC: write `result` and all three flags, pulse `done`, clear `busy`, next state is IDLE.
- Arithmetic (all unsigned, zero-extended to 2*WIDTH):
  - add: a+b.
  - subtract: |a−b|, with `negative` = (b > a).
  - multiply: a*b.
  - divide: quotient floor(a/b); the remainder is discarded.
  - divide by zero: result 0, `div_err`=1.
- `overflow` = (result > 999_999); the display wraps modulo 10^6, and this flag alerts the user.
- Flags not applicable to an operation are written 0 at EXEC.
- A start while busy is ignored entirely and not queued.
- `a`, `b` and `op` may change freely after capture without effect.

## Timing
- Reset values: state IDLE; `busy`, `done`, `result`, `negative`, `overflow` and `div_err` all 0.
- Let the accepting edge be k.
- Add, subtract, and divide by zero:
  - `busy` is high after k.
  - `result`, flags and `done` update at edge k+1.
  - latency is 1 cycle.
- Multiply and divide (b != 0):
  - iterations occur at edges k+1 .. k+WIDTH.
  - EXEC write-back occurs at k+WIDTH+1, so latency is WIDTH+1 = 11 cycles.
- `busy` is high from k until the write-back edge; `done` is high for exactly the following cycle.
- A start in the cycle where `done` is high is accepted, since the FSM is already in IDLE. Back-to-back operations are therefore legal.
- A reset asserted mid-operation forces all reset values immediately. No `done` is emitted and the previous `result` is lost.

## Structure
- Package `mini_alu_pkg`:
  - `op_t` enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - `state_t` enum (IDLE, CALC, EXEC).
  - `DISPLAY_MAX` = 999_999.
- Sub-module `alu_iter_unit`: shared shift-add / restoring-divide datapath with accumulator, shift register and counter. It takes a load strobe, a mode and operands, and returns the product or quotient. The top level owns the FSM, add/subtract and flags.

## Test plan
- Add a=1023, b=1023 → result 2046, `done` one cycle after the start edge, all flags 0.
- Subtract a=5, b=12 → result 7, `negative`=1. Then subtract a=12, b=5 → result 7, `negative`=0.
- Multiply a=1023, b=1023 → result 1_046_529 and `overflow`=1. `busy` is high for 11 cycles and `done` asserts at edge k+11. Multiply 0×517 → result 0.
- Divide a=1000, b=7 → result 142 after 11 cycles. Divide a=5, b=0 → result 0, `div_err`=1, latency 1 cycle.
- Start pulse mid-multiply with different operands → ignored; the original product is returned. A start in the `done` cycle → accepted; the second result follows at the correct latency.
- Assert `rst` at cycle 5 of a divide → `busy`=0, `result`=0, all flags 0 immediately. No `done` pulse appears afterward.
